// File: rtl/noise_lfsr_mc_if.sv
// Control/data bundle for the multi-channel LFSR noise source.
//
// Signals:
//   ena        refresh request (ignored while busy)
//   seed_load  load seed into the LFSR (honoured only when idle)
//   seed       seed value, LFSR_W bits
//   filt_en    per-channel low-pass enable, bit k = channel k
//   bw         per-channel filter shift, channel k uses bw[5k+4:5k]
//   out        packed signed samples, channel k at out[OUT_W*k +: OUT_W]
//   busy       refresh sequence in progress
//   done       one-cycle pulse after the last channel is updated
//
// Modports: master drives requests (e.g. voice controller or bench),
//           slave is the noise source itself.
interface noise_lfsr_mc_if #(
  parameter int LFSR_W = 64,
  parameter int CH     = 4,
  parameter int OUT_W  = 18
);
  logic                  ena;
  logic                  seed_load;
  logic [LFSR_W-1:0]     seed;
  logic [CH-1:0]         filt_en;
  logic [5*CH-1:0]       bw;
  logic [CH*OUT_W-1:0]   out;
  logic                  busy;
  logic                  done;

  modport master (
    output ena, seed_load, seed, filt_en, bw,
    input  out, busy, done
  );

  modport slave (
    input  ena, seed_load, seed, filt_en, bw,
    output out, busy, done
  );
endinterface

// File: rtl/noise_lfsr_mc.sv
// Multi-channel LFSR noise source with per-channel one-pole low-pass filter.
//
// One shared Fibonacci LFSR is stepped OUT_W times per channel for every
// accepted refresh request; the low OUT_W bits then become that channel's
// raw signed sample, optionally smoothed by acc += ((x<<31) - acc) >>> bw.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   noise_lfsr_mc_if slave modport (ena, seed_load, seed, filt_en,
//         bw in; out, busy, done out)
module noise_lfsr_mc #(
  parameter int                LFSR_W = 64,
  parameter logic [LFSR_W-1:0] TAPS   = 64'hD800000000000000,
  parameter logic [LFSR_W-1:0] SEED   = 64'h461B87AA9928112E,
  parameter int                CH     = 4,
  parameter int                OUT_W  = 18
) (
  input  logic           clk,
  input  logic           rst,
  noise_lfsr_mc_if.slave bus
);

  localparam int ACC_W  = OUT_W + 31;
  localparam int DIFF_W = OUT_W + 32;
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int CNT_W  = $clog2(OUT_W);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  logic [1:0]          state_r;
  logic [CH_W-1:0]     ch_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [LFSR_W-1:0]   sr_r;
  logic [ACC_W-1:0]    acc_r [CH];
  logic [CH*OUT_W-1:0] out_r;
  logic                busy_r;
  logic                done_r;

  logic                      fb_s;
  logic [LFSR_W-1:0]         seed_sel_s;
  logic                      filt_cur_s;
  logic [4:0]                bw_cur_s;
  logic [ACC_W-1:0]          acc_cur_s;
  logic signed [DIFF_W-1:0]  x_wide_s;
  logic signed [DIFF_W-1:0]  acc_wide_s;
  logic signed [DIFF_W-1:0]  diff_s;
  logic signed [DIFF_W-1:0]  shr_s;
  logic [ACC_W-1:0]          acc_new_s;
  logic                      unused_shr_msb_s;

  assign fb_s       = ^(sr_r & TAPS);
  // An all-zero seed would lock the LFSR up, so it is replaced by SEED.
  assign seed_sel_s = (bus.seed == {LFSR_W{1'b0}}) ? SEED : bus.seed;

  // Sample scaled to accumulator position, sign-extended by one guard bit
  // so the difference cannot overflow.
  assign x_wide_s   = {sr_r[OUT_W-1], sr_r[OUT_W-1:0], 31'd0};
  assign acc_wide_s = {acc_cur_s[ACC_W-1], acc_cur_s};
  assign diff_s     = x_wide_s - acc_wide_s;
  assign shr_s      = diff_s >>> bw_cur_s;
  // The shifted step always fits back into ACC_W bits; the guard bit is dropped.
  assign unused_shr_msb_s = shr_s[DIFF_W-1];

  // Select the accumulator and filter controls of the channel being updated.
  always_comb begin
    acc_cur_s  = {ACC_W{1'b0}};
    filt_cur_s = 1'b0;
    bw_cur_s   = 5'd0;
    for (int k = 0; k < CH; k++) begin
      if (ch_r == CH_W'(k)) begin
        acc_cur_s  = acc_r[k];
        filt_cur_s = bus.filt_en[k];
        bw_cur_s   = bus.bw[5*k +: 5];
      end else begin
        acc_cur_s  = acc_cur_s;
        filt_cur_s = filt_cur_s;
        bw_cur_s   = bw_cur_s;
      end
    end
  end

  // Next accumulator value: filtered step, or a jump straight to the sample
  // so that re-enabling the filter later starts without a step.
  always_comb begin
    acc_new_s = x_wide_s[ACC_W-1:0];
    if (filt_cur_s) begin
      acc_new_s = acc_cur_s + shr_s[ACC_W-1:0];
    end else begin
      acc_new_s = x_wide_s[ACC_W-1:0];
    end
  end

  // Sequencer: IDLE -> (RUN x OUT_W -> UPD) per channel -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      ch_r    <= {CH_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      sr_r    <= SEED;
      out_r   <= {(CH*OUT_W){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.seed_load) begin
            sr_r <= seed_sel_s;
          end else if (bus.ena) begin
            state_r <= S_RUN;
            ch_r    <= {CH_W{1'b0}};
            cnt_r   <= CNT_LAST;
            busy_r  <= 1'b1;
          end
        end
        S_RUN: begin
          sr_r <= {sr_r[LFSR_W-2:0], fb_s};
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= S_UPD;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        S_UPD: begin
          for (int k = 0; k < CH; k++) begin
            if (ch_r == CH_W'(k)) begin
              acc_r[k]                 <= acc_new_s;
              out_r[k*OUT_W +: OUT_W]  <= acc_new_s[ACC_W-1:31];
            end
          end
          if (ch_r == CH_LAST) begin
            state_r <= S_IDLE;
            ch_r    <= {CH_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_RUN;
            ch_r    <= ch_r + CH_W'(1'b1);
            cnt_r   <= CNT_LAST;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ch_r    <= {CH_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_noise_lfsr_mc.sv
// Self-checking bench for noise_lfsr_mc: a cycle-level model predicts busy,
// done and the output vector of the 4-channel instance; a second 1-channel
// instance checks seed handling and LFSR advance against fixed values.
module tb_noise_lfsr_mc;
  localparam int LFSR_W = 64;
  localparam int CH     = 4;
  localparam int OUT_W  = 18;
  localparam int SEQ    = CH * (OUT_W + 1);
  localparam logic [63:0] TAPS = 64'hD800000000000000;
  localparam logic [63:0] SEED = 64'h461B87AA9928112E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noise_lfsr_mc_if #(.LFSR_W(LFSR_W), .CH(CH), .OUT_W(OUT_W)) bus ();
  noise_lfsr_mc_if #(.LFSR_W(LFSR_W), .CH(1), .OUT_W(OUT_W)) bus_b ();

  noise_lfsr_mc #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED), .CH(CH), .OUT_W(OUT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  noise_lfsr_mc #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED), .CH(1), .OUT_W(OUT_W))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [63:0]         m_sr = SEED;
  longint              m_acc [CH];
  int                  m_left = 0;
  logic [CH*OUT_W-1:0] sb_q [$];
  logic [CH*OUT_W-1:0] rec_a [$];
  logic [CH*OUT_W-1:0] rec_b [$];
  logic [CH*OUT_W-1:0] last_exp = '0;
  int                  rec_sel = 0;

  function automatic logic [CH*OUT_W-1:0] model_refresh();
    logic [CH*OUT_W-1:0] v;
    longint x, d, na;
    logic [4:0]  b;
    logic [63:0] o;
    v = '0;
    for (int k = 0; k < CH; k++) begin
      for (int s = 0; s < OUT_W; s++) m_sr = {m_sr[62:0], ^(m_sr & TAPS)};
      x = longint'($signed(m_sr[OUT_W-1:0]));
      b = bus.bw[k*5 +: 5];
      if (bus.filt_en[k]) begin
        d  = (x <<< 31) - m_acc[k];
        na = m_acc[k] + (d >>> b);
        na = (na <<< 15) >>> 15;   // keep OUT_W+31 = 49 signed bits
      end else begin
        na = x <<< 31;
      end
      m_acc[k] = na;
      o = 64'(na >>> 31);
      v[k*OUT_W +: OUT_W] = o[OUT_W-1:0];
    end
    return v;
  endfunction

  // Scoreboard: at each negedge, account for what the preceding posedge did.
  always @(negedge clk) begin : sb_monitor
    int prev;
    logic exp_done;
    logic [CH*OUT_W-1:0] exp_v;
    if (rst) begin
      m_sr = SEED;
      for (int k = 0; k < CH; k++) m_acc[k] = 0;
      sb_q.delete();
      m_left = 0;
    end else begin
      prev = m_left;
      if (prev > 0) m_left = prev - 1;
      exp_done = (prev == 1);
      if (prev == 0) begin
        if (bus.seed_load) m_sr = (bus.seed == 64'h0) ? SEED : bus.seed;
        else if (bus.ena) begin
          sb_q.push_back(model_refresh());
          m_left = SEQ;
        end
      end
      check("done", bus.done, exp_done);
      check("busy", bus.busy, m_left != 0);
      if (exp_done) begin
        check("sb_depth", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          exp_v = sb_q.pop_front();
          last_exp = exp_v;
          check("out", bus.out, exp_v);
          if (rec_sel == 1) rec_a.push_back(exp_v);
          if (rec_sel == 2) rec_b.push_back(bus.out);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_out", bus.out, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_ena();
    @(negedge clk);
    #1 bus.ena = 1'b1;
    @(negedge clk);
    #1 bus.ena = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 1'b0, 1'b1);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int dt [$];
    logic [CH*OUT_W-1:0] ref_v;
    logic [OUT_W-1:0] v;
    bus.ena = 1'b0; bus.seed_load = 1'b0; bus.seed = '0; bus.filt_en = '0; bus.bw = '0;
    bus_b.ena = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed = '0; bus_b.filt_en = '0; bus_b.bw = '0;

    // Power-on reset values
    @(negedge clk);
    #1;
    check("por_out", bus.out, '0);
    check("por_busy", bus.busy, 1'b0);
    check("por_done", bus.done, 1'b0);
    rst = 1'b0;

    // Single-channel instance: seed handling and exact LFSR advance
    @(negedge clk); #1 bus_b.seed = 64'h1; bus_b.seed_load = 1'b1;
    @(negedge clk); #1 bus_b.seed_load = 1'b0;
    check("b_seed1", dut_b.sr_r, 64'h1);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1 bus_b.ena = 1'b1;
      @(negedge clk); #1 bus_b.ena = 1'b0;
      n = 0;
      while (!bus_b.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b_lat", n, 19);
      check("b_out", bus_b.out, 18'h0);
      check("b_sr", dut_b.sr_r, (r == 0) ? 64'h40000 : 64'h1000000000);
    end
    @(negedge clk); #1 bus_b.seed = 64'h0; bus_b.seed_load = 1'b1;
    @(negedge clk); #1 bus_b.seed_load = 1'b0;
    check("b_seed0", dut_b.sr_r, SEED);
    @(negedge clk); #1 bus_b.seed = 64'h5; bus_b.seed_load = 1'b1; bus_b.ena = 1'b1;
    @(negedge clk); #1 bus_b.seed_load = 1'b0; bus_b.ena = 1'b0;
    check("b_prio_sr", dut_b.sr_r, 64'h5);
    check("b_prio_busy", bus_b.busy, 1'b0);
    @(negedge clk);
    check("b_prio_busy2", bus_b.busy, 1'b0);

    // First refresh from SEED, unfiltered
    do_reset();
    pulse_ena();
    wait_done(n);
    check("lat", n, SEQ);

    // bw=0 filtered stream equals unfiltered stream
    do_reset();
    bus.filt_en = 4'b1111; bus.bw = '0; rec_sel = 1;
    for (int r = 0; r < 100; r++) begin pulse_ena(); wait_done(n); end
    do_reset();
    bus.filt_en = 4'b0000; rec_sel = 2;
    for (int r = 0; r < 100; r++) begin pulse_ena(); wait_done(n); end
    rec_sel = 0;
    check("stream_len", rec_b.size(), 100);
    for (int r = 0; r < 100 && r < rec_a.size() && r < rec_b.size(); r++)
      check("bw0_vs_raw", rec_b[r], rec_a[r]);

    // bw=31: outputs remain at the sign level of a tiny accumulator
    do_reset();
    bus.filt_en = 4'b1111; bus.bw = {4{5'd31}};
    for (int r = 0; r < 10; r++) begin
      pulse_ena();
      wait_done(n);
      for (int k = 0; k < CH; k++) begin
        v = bus.out[k*OUT_W +: OUT_W];
        check("bw31_range", (v == 18'h0) || (v == 18'h3FFFF), 1'b1);
      end
    end

    // ena held high: back-to-back sequences every SEQ+1 cycles
    do_reset();
    bus.filt_en = 4'b0000; bus.bw = '0;
    @(negedge clk); #1 bus.ena = 1'b1;
    for (int c = 0; c < 240; c++) begin
      @(negedge clk);
      if (bus.done) dt.push_back(c);
    end
    #1 bus.ena = 1'b0;
    check("held_pulses", dt.size(), 3);
    for (int i = 1; i < dt.size(); i++) check("held_period", dt[i] - dt[i-1], SEQ + 1);
    wait_done(n);

    // Reset mid-sequence, then replay of the first post-reset refresh
    do_reset();
    bus.filt_en = 4'b1111; bus.bw = {5'd2, 5'd5, 5'd9, 5'd1};
    pulse_ena();
    wait_done(n);
    ref_v = last_exp;
    do_reset();
    pulse_ena();
    repeat (39) @(negedge clk);
    do_reset();
    pulse_ena();
    wait_done(n);
    check("rst_replay", bus.out, ref_v);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
